// File: rtl/drac_led_sequencer.sv
// rtl/drac_led_sequencer.sv - dRAC front-panel LED colour store, mode sequencer and ws2811 lookup
module drac_led_sequencer #(
    parameter int         NUM_LEDS     = 7,
    parameter int         SYSTEM_CLOCK = 49_152_000,
    parameter logic [3:0] ADDR_SPACE   = 4'hA
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        enable,
    input  logic        fault,
    input  logic [15:0] reg_waddr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_wen,
    input  logic [15:0] reg_raddr,
    output logic [31:0] reg_rdata,
    input  logic [3:0]  led_address,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out
);

    localparam int TICK   = SYSTEM_CLOCK / 4;
    localparam int TCNT_W = (TICK > 1) ? $clog2(TICK) : 1;

    typedef enum logic [1:0] {
        MODE_CHASE = 2'd0,
        MODE_HOST  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_OFF   = 2'd3
    } mode_t;

    mode_t              mode, mode_n;
    logic [TCNT_W-1:0]  tcnt, tcnt_n;
    logic [3:0]         pos, pos_n;
    logic               phase, phase_n;
    logic [23:0]        color [NUM_LEDS];
    logic               tick, wsel, ctrl_wr, rsel;
    logic [23:0]        host_px, pixel;
    logic               unused_bits;

    assign unused_bits = ^reg_wdata[31:24];
    assign wsel    = reg_wen && (reg_waddr[15:12] == ADDR_SPACE) && (reg_waddr[11:4] == 8'd0);
    assign ctrl_wr = wsel && (reg_waddr[3:0] == 4'd0);
    assign rsel    = (reg_raddr[15:12] == ADDR_SPACE) && (reg_raddr[11:4] == 8'd0);
    assign tick    = (tcnt == TCNT_W'(TICK - 1));

    // A CTRL write restarts the pattern and overrides a coincident tick.
    always_comb begin
        mode_n  = mode;
        tcnt_n  = tcnt + 1'b1;
        pos_n   = pos;
        phase_n = phase;
        if (ctrl_wr) begin
            mode_n  = mode_t'(reg_wdata[1:0]);
            tcnt_n  = '0;
            phase_n = 1'b1;
            if (mode_t'(reg_wdata[1:0]) == MODE_CHASE)
                pos_n = 4'd1;
        end else if (tick) begin
            tcnt_n  = '0;
            phase_n = ~phase;
            pos_n   = (pos == 4'(NUM_LEDS - 1)) ? 4'd1 : pos + 4'd1;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            mode  <= MODE_CHASE;
            tcnt  <= '0;
            pos   <= 4'd1;
            phase <= 1'b1;
        end else begin
            mode  <= mode_n;
            tcnt  <= tcnt_n;
            pos   <= pos_n;
            phase <= phase_n;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LEDS; i++)
                color[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_LEDS; i++)
                if (wsel && reg_waddr[3:0] == 4'(i + 1))
                    color[i] <= reg_wdata[23:0];
        end
    end

    always_comb begin
        reg_rdata = '0;
        if (rsel) begin
            if (reg_raddr[3:0] == 4'd0)
                reg_rdata = {30'd0, mode};
            for (int i = 0; i < NUM_LEDS; i++)
                if (reg_raddr[3:0] == 4'(i + 1))
                    reg_rdata = {8'd0, color[i]};
        end
    end

    always_comb begin
        host_px = '0;
        for (int i = 0; i < NUM_LEDS; i++)
            if (led_address == 4'(i))
                host_px = color[i];
        pixel = '0;
        if (!enable) begin
            pixel = '0;
        end else if (fault) begin
            pixel = 24'h40_00_00;
        end else if (led_address < 4'(NUM_LEDS)) begin
            case (mode)
                MODE_CHASE: pixel = (led_address == pos) ? 24'h00_32_00 : 24'h0;
                MODE_HOST:  pixel = host_px;
                MODE_BLINK: pixel = phase ? host_px : 24'h0;
                default:    pixel = '0;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
        end else begin
            {red_out, green_out, blue_out} <= pixel;
        end
    end

endmodule
